// File: rtl/multi_timer.sv
// Multi-channel programmable down-counter with shared tick prescaler and coherent count reads.
// Define MULTI_TIMER_COMPARE_EN to build the per-channel compare registers and match irqs.
module multi_timer #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter logic [23:0] BASE_ADDR   = 24'h2018
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    bus_write,
    input  logic                    bus_read,
    input  logic [23:0]             bus_address_in,
    input  logic [7:0]              bus_data_in,
    output logic [7:0]              bus_data_out,
    output logic [2*CHANNELS-1:0]   irqs
);

    typedef logic [COUNT_WIDTH-1:0] cnt_t;

    localparam logic [23:0] SPAN = 24'(8 * CHANNELS);

    logic [23:0] rel;
    logic        hit;
    logic [1:0]  ch_sel;
    logic [2:0]  reg_sel;
    logic [6:0]  pre;

    logic        en      [CHANNELS];
    logic        oneshot [CHANNELS];
    logic [2:0]  psel    [CHANNELS];
    cnt_t        count   [CHANNELS];
    cnt_t        preset  [CHANNELS];
    logic [7:0]  shadow  [CHANNELS];
    logic [15:0] count_x [CHANNELS];
    logic [15:0] preset_x[CHANNELS];
    logic        sel     [CHANNELS];
    logic        ctrl_wr [CHANNELS];
    logic        load    [CHANNELS];
    logic        fire    [CHANNELS];
    logic        irq_uf  [CHANNELS];
    logic        irq_cmp [CHANNELS];

    function automatic logic [6:0] pmask(input logic [2:0] s);
        return 7'((8'd1 << s) - 8'd1);
    endfunction

    assign rel     = bus_address_in - BASE_ADDR;
    assign hit     = (bus_address_in >= BASE_ADDR) && (rel < SPAN);
    assign ch_sel  = rel[4:3];
    assign reg_sel = rel[2:0];

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            count_x[i]  = 16'(count[i]);
            preset_x[i] = 16'(preset[i]);
            sel[i]      = hit && (ch_sel == 2'(i));
            ctrl_wr[i]  = bus_write && sel[i] && (reg_sel == 3'd0);
            load[i]     = ctrl_wr[i] && bus_data_in[1];
            fire[i]     = tick && en[i] && ((pre & pmask(psel[i])) == pmask(psel[i]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                en[i]      <= 1'b0;
                oneshot[i] <= 1'b0;
                psel[i]    <= '0;
                count[i]   <= '0;
                preset[i]  <= '0;
                shadow[i]  <= '0;
                irq_uf[i]  <= 1'b0;
            end
        end else begin
            if (tick)
                pre <= pre + 7'd1;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                // A load strobe swallows a coincident count event, including its irq.
                irq_uf[i] <= fire[i] && (count[i] == '0) && !load[i];

                if (ctrl_wr[i]) begin
                    en[i]      <= bus_data_in[0];
                    oneshot[i] <= bus_data_in[2];
                    psel[i]    <= bus_data_in[6:4];
                end else if (fire[i] && (count[i] == '0) && oneshot[i]) begin
                    en[i] <= 1'b0;
                end

                if (load[i])
                    count[i] <= preset[i];
                else if (fire[i]) begin
                    if (count[i] != '0)
                        count[i] <= count[i] - cnt_t'(1);
                    else if (!oneshot[i])
                        count[i] <= preset[i];
                end

                if (bus_write && sel[i] && (reg_sel == 3'd2))
                    preset[i] <= cnt_t'({preset_x[i][15:8], bus_data_in});
                if (bus_write && sel[i] && (reg_sel == 3'd3))
                    preset[i] <= cnt_t'({bus_data_in, preset_x[i][7:0]});

                if (bus_read && sel[i] && (reg_sel == 3'd6))
                    shadow[i] <= count_x[i][15:8];
            end
        end
    end

`ifdef MULTI_TIMER_COMPARE_EN
    cnt_t        compare  [CHANNELS];
    logic [15:0] compare_x[CHANNELS];

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++)
            compare_x[i] = 16'(compare[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                compare[i] <= '0;
                irq_cmp[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                // Only a decrement can match; reloads never raise the compare irq.
                irq_cmp[i] <= fire[i] && !load[i] && (count[i] != '0)
                              && (cnt_t'(count[i] - cnt_t'(1)) == compare[i]);
                if (bus_write && sel[i] && (reg_sel == 3'd4))
                    compare[i] <= cnt_t'({compare_x[i][15:8], bus_data_in});
                if (bus_write && sel[i] && (reg_sel == 3'd5))
                    compare[i] <= cnt_t'({bus_data_in, compare_x[i][7:0]});
            end
        end
    end
`else
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++)
            irq_cmp[i] = 1'b0;
    end
`endif

    always_comb begin
        irqs = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            irqs[2*i]   = irq_uf[i];
            irqs[2*i+1] = irq_cmp[i];
        end
    end

    always_comb begin
        bus_data_out = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel[i]) begin
                case (reg_sel)
                    3'd0: bus_data_out = {1'b0, psel[i], 1'b0, oneshot[i], 1'b0, en[i]};
                    3'd2: bus_data_out = preset_x[i][7:0];
                    3'd3: bus_data_out = preset_x[i][15:8];
`ifdef MULTI_TIMER_COMPARE_EN
                    3'd4: bus_data_out = compare_x[i][7:0];
                    3'd5: bus_data_out = compare_x[i][15:8];
`endif
                    3'd6: bus_data_out = count_x[i][7:0];
                    3'd7: bus_data_out = shadow[i];
                    default: bus_data_out = '0;
                endcase
            end
        end
    end

endmodule
